// File: rtl/control_pkg.sv
// Shared opcode, ALUOp and control-word definitions for the control unit.
package control_pkg;

  localparam logic [3:0] OP_ATYPE = 4'b0000;
  localparam logic [3:0] OP_BLT   = 4'b0100;
  localparam logic [3:0] OP_BGT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // alu_op[1] is ALUOp1, alu_op[0] is ALUOp0
  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_word_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode-to-control-word mapping; unlisted opcodes decode as NOP.
module control_decode
  import control_pkg::*;
(
  input  logic [3:0] opcode_i,
  output ctrl_word_t ctrl_o,
  output logic       halt_o
);

  always_comb begin
    ctrl_o = '0;
    halt_o = 1'b0;
    unique case (opcode_i)
      OP_ATYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
      end
      OP_BLT, OP_BGT, OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
      end
      OP_JMP:  ctrl_o.jump = 1'b1;
      OP_HALT: halt_o      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Registered main control decoder with halt tracking.
// Build option: CONTROL_HALT_LATCH_EN makes Halt sticky and forces other outputs low.
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic       Branch,
  output logic       Jump,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       MemRead,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       Halt
);

  ctrl_word_t dec_ctrl;
  logic       dec_halt;
  ctrl_word_t ctrl_d, ctrl_q;
  logic       halt_d, halt_q;

  control_decode u_decode (
    .opcode_i (opcode),
    .ctrl_o   (dec_ctrl),
    .halt_o   (dec_halt)
  );

  always_comb begin
    ctrl_d = dec_ctrl;
    halt_d = dec_halt;
`ifdef CONTROL_HALT_LATCH_EN
    // Once halted, hold Halt and suppress every strobe until reset.
    if (halt_q) begin
      ctrl_d = '0;
      halt_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      halt_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      halt_q <= halt_d;
    end
  end

  assign Branch   = ctrl_q.branch;
  assign Jump     = ctrl_q.jump;
  assign RegDst   = ctrl_q.reg_dst;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign MemRead  = ctrl_q.mem_read;
  assign ALUOp1   = ctrl_q.alu_op[1];
  assign ALUOp0   = ctrl_q.alu_op[0];
  assign MemWrite = ctrl_q.mem_write;
  assign ALUSrc   = ctrl_q.alu_src;
  assign RegWrite = ctrl_q.reg_write;
  assign Halt     = halt_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: vector table, halt/reset sequences, random run vs model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'b0000;
  logic Branch, Jump, RegDst, MemtoReg, MemRead, ALUOp1, ALUOp0;
  logic MemWrite, ALUSrc, RegWrite, Halt;

  int errors = 0;
  int checks = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .Branch(Branch), .Jump(Jump), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .MemRead(MemRead), .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Halt(Halt)
  );

  always #5 clk = ~clk;

  // {Branch,Jump,RegDst,MemtoReg,MemRead,ALUOp1,ALUOp0,MemWrite,ALUSrc,RegWrite,Halt}
  localparam logic [10:0] E_ZERO  = 11'b000_0000_0000;
  localparam logic [10:0] E_ATYPE = 11'b00100100010;
  localparam logic [10:0] E_LW    = 11'b00011000110;
  localparam logic [10:0] E_SW    = 11'b00000001100;
  localparam logic [10:0] E_BR    = 11'b10000010000;
  localparam logic [10:0] E_JMP   = 11'b01000000000;
  localparam logic [10:0] E_HALT  = 11'b00000000001;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic [10:0] exp;
  } vec_t;

  function automatic logic [10:0] outs();
    return {Branch, Jump, RegDst, MemtoReg, MemRead, ALUOp1, ALUOp0,
            MemWrite, ALUSrc, RegWrite, Halt};
  endfunction

  // Reference: decode table from the opcode's meaning
  function automatic logic [10:0] ref_decode(input logic [3:0] op);
    case (op)
      4'b0000: return E_ATYPE;
      4'b1000: return E_LW;
      4'b1011: return E_SW;
      4'b0100, 4'b0101, 4'b0110: return E_BR;
      4'b1100: return E_JMP;
      4'b1111: return E_HALT;
      default: return E_ZERO;
    endcase
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] op);
    @(negedge clk);
    rst    = r;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  logic halted_m;
  logic [10:0] exp_m;

  initial begin
    // Reset held 2 cycles with lw present, then decode sequence and NOPs
    vecs.push_back('{1'b1, 4'b1000, E_ZERO});
    vecs.push_back('{1'b1, 4'b1000, E_ZERO});
    vecs.push_back('{1'b0, 4'b1000, E_LW});
    vecs.push_back('{1'b0, 4'b0000, E_ATYPE});
    vecs.push_back('{1'b0, 4'b1000, E_LW});
    vecs.push_back('{1'b0, 4'b1011, E_SW});
    vecs.push_back('{1'b0, 4'b0100, E_BR});
    vecs.push_back('{1'b0, 4'b0101, E_BR});
    vecs.push_back('{1'b0, 4'b0110, E_BR});
    vecs.push_back('{1'b0, 4'b1100, E_JMP});
    vecs.push_back('{1'b0, 4'b0011, E_ZERO});
    vecs.push_back('{1'b0, 4'b1001, E_ZERO});
    vecs.push_back('{1'b0, 4'b0111, E_ZERO});
    vecs.push_back('{1'b0, 4'b1011, E_SW});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].op);
      check($sformatf("vec%0d op=%b rst=%b", i, vecs[i].op, vecs[i].rst), outs(), vecs[i].exp);
    end

    // Halt then A-type
    step(1'b1, 4'b0000);
    check("pre_halt_reset", outs(), E_ZERO);
    step(1'b0, 4'b1111);
    check("halt_set", outs(), E_HALT);
    step(1'b0, 4'b0000);
`ifdef CONTROL_HALT_LATCH_EN
    check("halt_sticky_atype", outs(), E_HALT);
    step(1'b0, 4'b1011);
    check("halt_sticky_sw", outs(), E_HALT);
    step(1'b0, 4'b1000);
    check("halt_sticky_lw", outs(), E_HALT);
`else
    check("halt_falls_atype", outs(), E_ATYPE);
    step(1'b0, 4'b1011);
    check("after_halt_sw", outs(), E_SW);
`endif
    // Reset clears halt; reset wins over a simultaneous halt opcode
    step(1'b1, 4'b1111);
    check("rst_with_halt_op", outs(), E_ZERO);
    step(1'b0, 4'b0110);
    check("post_rst_beq", outs(), E_BR);
    step(1'b0, 4'b1111);
    step(1'b1, 4'b0000);
    check("rst_clears_halt", outs(), E_ZERO);
    step(1'b0, 4'b0000);
    check("post_rst_atype", outs(), E_ATYPE);

    // Random run against the model
    halted_m = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [3:0] op;
      r  = ($urandom_range(0, 19) == 0);
      op = 4'($urandom_range(0, 15));
      step(r, op);
      if (r) begin
        exp_m = E_ZERO;
        halted_m = 1'b0;
      end else begin
`ifdef CONTROL_HALT_LATCH_EN
        if (halted_m) exp_m = E_HALT;
        else exp_m = ref_decode(op);
        halted_m = halted_m || (op == 4'b1111);
`else
        exp_m = ref_decode(op);
`endif
      end
      check($sformatf("rand%0d op=%b rst=%b", i, op, r), outs(), exp_m);
      checks++;
      if (MemRead && MemWrite) begin
        errors++;
        $display("FAIL rand%0d rd_wr_excl: MemRead=%b MemWrite=%b required not both 1", i, MemRead, MemWrite);
      end
      checks++;
      if (RegWrite && MemWrite) begin
        errors++;
        $display("FAIL rand%0d regw_memw_excl: RegWrite=%b MemWrite=%b required not both 1", i, RegWrite, MemWrite);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Main control decoder for the 4-bit-opcode single-issue datapath. It sits between instruction fetch and the datapath. It turns the instruction opcode into the register-file, ALU, memory, branch and jump control strobes. It also latches the halt condition. All control outputs are registered on the single system clock.

## Interface
- No parameters.
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset; one clock, reset is synchronous and active-high
- opcode  input  4  instruction opcode, bits [15:12] of the current instruction
- Branch  output  1  conditional branch (blt/bgt/beq)
- Jump  output  1  unconditional jump
- RegDst  output  1  1 = write register from rd field, 0 = from rt field
- MemtoReg  output  1  1 = write-back data from memory, 0 = from ALU
- MemRead  output  1  data-memory read enable
- ALUOp1  output  1  ALU operation class, MSB
- ALUOp0  output  1  ALU operation class, LSB
- MemWrite  output  1  data-memory write enable
- ALUSrc  output  1  1 = ALU operand B is the immediate, 0 = register
- RegWrite  output  1  register-file write enable
- Halt  output  1  processor halted

## Operation
Decode table; every signal not listed is 0:
- 0000 A-type: RegDst=1, RegWrite=1, ALUOp=10.
- 1000 lw: ALUSrc=1, MemtoReg=1, MemRead=1, RegWrite=1, ALUOp=00.
- 1011 sw: ALUSrc=1, MemWrite=1, ALUOp=00.
- 0100 blt, 0101 bgt, 0110 beq: Branch=1, ALUOp=01 (subtract/compare). The branch comparator downstream uses opcode[1:0] to pick the condition.
- 1100 jmp: Jump=1.
- 1111 halt: all strobes 0, Halt=1.
- Any other opcode: all strobes 0, Halt=0 (NOP).

Halt rules:
- Once Halt is set (see Configuration), it stays 1 until rst.
- While Halt=1, every other output is forced to 0 regardless of opcode. No write or branch can leak after halt.
- MemRead and MemWrite are never both 1. RegWrite=1 together with MemWrite=1 never occurs.

## Timing
- Outputs are registered. The opcode sampled at rising edge N drives the outputs from edge N until edge N+1. Latency is 1 cycle, with no handshake.
- A new opcode can be accepted every cycle.
- Reset value: every output is 0, including Halt. rst takes priority over opcode decode and over the halt latch.
- rst asserted in the same cycle as opcode=1111: outputs 0 and Halt=0 after the edge.
- rst released: the first edge with rst=0 decodes the opcode present then.

## Configuration
- Macro CONTROL_HALT_LATCH_EN.
- Defined: Halt is sticky as described above, and outputs stay forced to 0 until reset.
- Undefined: Halt is a plain registered decode of opcode==1111. It falls on the next non-halt opcode, and no output forcing is applied.

## Structure
- Package control_pkg holds:
  - opcode localparams OP_ATYPE, OP_LW, OP_SW, OP_BLT, OP_BGT, OP_BEQ, OP_JMP, OP_HALT;
  - ALUOp encodings ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10;
  - a packed control-word typedef ordered Branch, Jump, RegDst, MemtoReg, MemRead, ALUOp1, ALUOp0, MemWrite, ALUSrc, RegWrite.
- Sub-module control_decode: purely combinational opcode-to-control-word mapping.
- The top module holds the output register, reset and halt latch.

## Test plan
- rst=1 for 2 cycles with opcode=1000 -> all outputs 0. After release, the next edge gives MemRead=1, MemtoReg=1, ALUSrc=1, RegWrite=1, ALUOp=00.
- Opcode sequence 0000,1000,1011,0100,0101,0110,1100, one per cycle -> each cycle's outputs match the decode table exactly, delayed by one edge.
- Opcode 0011 and 1001 -> all outputs 0, Halt=0.
- Opcode 1111, then 0000, with CONTROL_HALT_LATCH_EN defined -> Halt=1 and stays 1; RegDst and RegWrite stay 0. rst then clears Halt.
- Same sequence without the macro -> Halt=1 for one cycle, then A-type controls (RegDst=1, RegWrite=1, ALUOp=10) and Halt=0.
- Every cycle of a random opcode run -> never MemRead&MemWrite, never RegWrite&MemWrite.
